// File: rtl/clock_calendar_core_pkg.sv
// Shared widths, field selectors and month constants for the clock/calendar core.
package clk_cal_pkg;

  localparam int SS_W   = 6;
  localparam int MM_W   = 6;
  localparam int HH_W   = 5;
  localparam int DAY_W  = 5;
  localparam int MON_W  = 4;
  localparam int YEAR_W = 12;

  localparam logic [2:0] FLD_SS   = 3'd0;
  localparam logic [2:0] FLD_MM   = 3'd1;
  localparam logic [2:0] FLD_HH   = 3'd2;
  localparam logic [2:0] FLD_DAY  = 3'd3;
  localparam logic [2:0] FLD_MON  = 3'd4;
  localparam logic [2:0] FLD_YEAR = 3'd5;

  localparam logic [MON_W-1:0] JAN = 4'd1;
  localparam logic [MON_W-1:0] FEB = 4'd2;
  localparam logic [MON_W-1:0] APR = 4'd4;
  localparam logic [MON_W-1:0] JUN = 4'd6;
  localparam logic [MON_W-1:0] SEP = 4'd9;
  localparam logic [MON_W-1:0] NOV = 4'd11;
  localparam logic [MON_W-1:0] DEC = 4'd12;

  localparam logic [SS_W-1:0] SS_MAX = 6'd59;
  localparam logic [MM_W-1:0] MM_MAX = 6'd59;
  localparam logic [HH_W-1:0] HH_MAX = 5'd23;

  // Divisible-by-4 is exact across 2000..2099 because 2000 is a 400-year.
  function automatic logic is_leap(input logic [YEAR_W-1:0] year);
    return (year[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/clock_calendar_core_if.sv
// Control inputs and time/date outputs of the clock/calendar core.
interface clock_calendar_core_if;
  import clk_cal_pkg::*;

  logic              tick;
  logic              set_en;
  logic [2:0]        set_field;
  logic              set_inc;
  logic [SS_W-1:0]   ss;
  logic [MM_W-1:0]   mm;
  logic [HH_W-1:0]   hh;
  logic [DAY_W-1:0]  day;
  logic [MON_W-1:0]  mon;
  logic [YEAR_W-1:0] year;
  logic              leap;
  logic              day_roll;

  modport master (
    output tick, set_en, set_field, set_inc,
    input  ss, mm, hh, day, mon, year, leap, day_roll
  );

  modport slave (
    input  tick, set_en, set_field, set_inc,
    output ss, mm, hh, day, mon, year, leap, day_roll
  );

endinterface

// File: rtl/clock_calendar_core_month_days.sv
// Days in a month (1..12) given the leap flag of the year.
module month_days
  import clk_cal_pkg::*;
(
  input  logic [MON_W-1:0] mon_i,
  input  logic             leap_i,
  output logic [DAY_W-1:0] dim_o
);

  always_comb begin
    case (mon_i)
      FEB:                dim_o = leap_i ? 5'd29 : 5'd28;
      APR, JUN, SEP, NOV: dim_o = 5'd30;
      default:            dim_o = 5'd31;
    endcase
  end

endmodule

// File: rtl/clock_calendar_core.sv
// hh:mm:ss plus day/month/year counter with leap years and a frozen-time set mode.
module clock_calendar_core
  import clk_cal_pkg::*;
#(
  parameter int YEAR_MIN = 2000,
  parameter int YEAR_MAX = 2099,
  parameter int RST_YEAR = 2022,
  parameter int RST_MON  = 11,
  parameter int RST_DAY  = 24
) (
  input  logic                  clk18,
  input  logic                  rst,
  clock_calendar_core_if.slave  bus
);

  localparam logic [YEAR_W-1:0] Y_MIN   = YEAR_W'(YEAR_MIN);
  localparam logic [YEAR_W-1:0] Y_MAX   = YEAR_W'(YEAR_MAX);
  localparam logic [YEAR_W-1:0] Y_RST   = YEAR_W'(RST_YEAR);
  localparam logic [MON_W-1:0]  MON_RST = MON_W'(RST_MON);
  localparam logic [DAY_W-1:0]  DAY_RST = DAY_W'(RST_DAY);

  logic [SS_W-1:0]   ss_q,   ss_d;
  logic [MM_W-1:0]   mm_q,   mm_d;
  logic [HH_W-1:0]   hh_q,   hh_d;
  logic [DAY_W-1:0]  day_q,  day_d;
  logic [MON_W-1:0]  mon_q,  mon_d;
  logic [YEAR_W-1:0] year_q, year_d;
  logic              day_roll_q, day_roll_d;

  logic              leap_cur, leap_cand;
  logic [DAY_W-1:0]  dim_cur, dim_cand;
  logic [MON_W-1:0]  mon_inc, cand_mon;
  logic [YEAR_W-1:0] year_inc, cand_year;
  logic              state_ok;

  assign leap_cur = is_leap(year_q);
  assign mon_inc  = (mon_q >= DEC) ? JAN : mon_q + 4'd1;
  assign year_inc = (year_q >= Y_MAX || year_q < Y_MIN) ? Y_MIN : year_q + 12'd1;

  // The clamp needs the month length of the date *after* a month/year set step.
  always_comb begin
    cand_mon  = mon_q;
    cand_year = year_q;
    if (bus.set_field == FLD_MON)  cand_mon  = mon_inc;
    if (bus.set_field == FLD_YEAR) cand_year = year_inc;
  end

  assign leap_cand = is_leap(cand_year);

  month_days u_dim_cur (
    .mon_i  (mon_q),
    .leap_i (leap_cur),
    .dim_o  (dim_cur)
  );

  month_days u_dim_cand (
    .mon_i  (cand_mon),
    .leap_i (leap_cand),
    .dim_o  (dim_cand)
  );

  assign state_ok = (ss_q <= SS_MAX) && (mm_q <= MM_MAX) && (hh_q <= HH_MAX) &&
                    (day_q != '0) && (day_q <= dim_cur) &&
                    (mon_q != '0) && (mon_q <= DEC) &&
                    (year_q >= Y_MIN) && (year_q <= Y_MAX);

  // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
  always_comb begin
    ss_d       = ss_q;
    mm_d       = mm_q;
    hh_d       = hh_q;
    day_d      = day_q;
    mon_d      = mon_q;
    year_d     = year_q;
    day_roll_d = 1'b0;

    if (!bus.set_en) begin
      if (bus.tick) begin
        if (!state_ok) begin
          ss_d   = '0;
          mm_d   = '0;
          hh_d   = '0;
          day_d  = DAY_RST;
          mon_d  = MON_RST;
          year_d = Y_RST;
        end else if (ss_q != SS_MAX) begin
          ss_d = ss_q + 6'd1;
        end else begin
          ss_d = '0;
          if (mm_q != MM_MAX) begin
            mm_d = mm_q + 6'd1;
          end else begin
            mm_d = '0;
            if (hh_q != HH_MAX) begin
              hh_d = hh_q + 5'd1;
            end else begin
              hh_d       = '0;
              day_roll_d = 1'b1;
              if (day_q != dim_cur) begin
                day_d = day_q + 5'd1;
              end else begin
                day_d = 5'd1;
                if (mon_q != DEC) begin
                  mon_d = mon_q + 4'd1;
                end else begin
                  mon_d  = JAN;
                  year_d = (year_q == Y_MAX) ? Y_MIN : year_q + 12'd1;
                end
              end
            end
          end
        end
      end
    end else if (bus.set_inc) begin
      case (bus.set_field)
        FLD_SS:  ss_d  = (ss_q >= SS_MAX) ? '0 : ss_q + 6'd1;
        FLD_MM:  mm_d  = (mm_q >= MM_MAX) ? '0 : mm_q + 6'd1;
        FLD_HH:  hh_d  = (hh_q >= HH_MAX) ? '0 : hh_q + 5'd1;
        FLD_DAY: day_d = (day_q >= dim_cur) ? 5'd1 : day_q + 5'd1;
        FLD_MON, FLD_YEAR: begin
          mon_d  = cand_mon;
          year_d = cand_year;
          if (day_q > dim_cand) day_d = dim_cand;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk18 or posedge rst) begin
    if (rst) begin
      ss_q       <= '0;
      mm_q       <= '0;
      hh_q       <= '0;
      day_q      <= DAY_RST;
      mon_q      <= MON_RST;
      year_q     <= Y_RST;
      day_roll_q <= 1'b0;
    end else begin
      ss_q       <= ss_d;
      mm_q       <= mm_d;
      hh_q       <= hh_d;
      day_q      <= day_d;
      mon_q      <= mon_d;
      year_q     <= year_d;
      day_roll_q <= day_roll_d;
    end
  end

  assign bus.ss       = ss_q;
  assign bus.mm       = mm_q;
  assign bus.hh       = hh_q;
  assign bus.day      = day_q;
  assign bus.mon      = mon_q;
  assign bus.year     = year_q;
  assign bus.leap     = leap_cur;
  assign bus.day_roll = day_roll_q;

endmodule

// File: tb/tb_clock_calendar_core.sv
// Randomised scoreboard bench for clock_calendar_core against a seconds-of-day calendar model.
module tb_clock_calendar_core;
  import clk_cal_pkg::*;

  logic clk18 = 1'b0;
  logic rst;
  always #5 clk18 = ~clk18;

  clock_calendar_core_if bus ();

  clock_calendar_core #(
    .YEAR_MIN (2000),
    .YEAR_MAX (2099),
    .RST_YEAR (2022),
    .RST_MON  (11),
    .RST_DAY  (24)
  ) dut (
    .clk18 (clk18),
    .rst   (rst),
    .bus   (bus)
  );

  typedef struct {
    int ss, mm, hh, day, mon, year;
    bit leap, roll;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  int m_ss, m_mm, m_hh, m_day, m_mon, m_year;
  bit m_roll;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dim(input int m, input int y);
    if (m == 2) return (y % 4 == 0) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  function automatic void model_reset();
    m_ss = 0; m_mm = 0; m_hh = 0;
    m_day = 24; m_mon = 11; m_year = 2022;
    m_roll = 0;
  endfunction

  function automatic void clamp_day();
    if (m_day > dim(m_mon, m_year)) m_day = dim(m_mon, m_year);
  endfunction

  function automatic void model_step(input bit t, input bit se, input int f, input bit inc);
    int sod;
    m_roll = 0;
    if (!se) begin
      if (t) begin
        sod = m_hh * 3600 + m_mm * 60 + m_ss + 1;
        if (sod == 86400) begin
          sod    = 0;
          m_roll = 1;
          m_day++;
          if (m_day > dim(m_mon, m_year)) begin
            m_day = 1;
            m_mon++;
            if (m_mon > 12) begin
              m_mon  = 1;
              m_year = (m_year == 2099) ? 2000 : m_year + 1;
            end
          end
        end
        m_hh = sod / 3600;
        m_mm = (sod / 60) % 60;
        m_ss = sod % 60;
      end
    end else if (inc) begin
      case (f)
        0: m_ss  = (m_ss + 1) % 60;
        1: m_mm  = (m_mm + 1) % 60;
        2: m_hh  = (m_hh + 1) % 24;
        3: m_day = m_day % dim(m_mon, m_year) + 1;
        4: begin m_mon = m_mon % 12 + 1; clamp_day(); end
        5: begin m_year = (m_year == 2099) ? 2000 : m_year + 1; clamp_day(); end
        default: ;
      endcase
    end
  endfunction

  function automatic int field_val(input int f);
    case (f)
      0: return m_ss;
      1: return m_mm;
      2: return m_hh;
      3: return m_day;
      4: return m_mon;
      default: return m_year;
    endcase
  endfunction

  // One clock of stimulus: drive at the falling edge, queue the state expected after the next rising edge.
  task automatic step(input bit t, input bit se, input int f, input bit inc);
    exp_t e;
    @(negedge clk18);
    bus.tick      = t;
    bus.set_en    = se;
    bus.set_field = 3'(f);
    bus.set_inc   = inc;
    model_step(t, se, f, inc);
    e.ss = m_ss; e.mm = m_mm; e.hh = m_hh;
    e.day = m_day; e.mon = m_mon; e.year = m_year;
    e.leap = (m_year % 4 == 0);
    e.roll = m_roll;
    exp_q.push_back(e);
  endtask

  task automatic set_to(input int f, input int target);
    for (int i = 0; i < 200 && field_val(f) != target; i++) step(0, 1, f, 1);
  endtask

  task automatic preload(input int y, input int mo, input int d, input int h, input int mi, input int s);
    set_to(5, y); set_to(4, mo); set_to(3, d);
    set_to(2, h); set_to(1, mi); set_to(0, s);
    step(0, 0, 7, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ss"},   bus.ss,       0);
    check({tag, "_mm"},   bus.mm,       0);
    check({tag, "_hh"},   bus.hh,       0);
    check({tag, "_day"},  bus.day,      24);
    check({tag, "_mon"},  bus.mon,      11);
    check({tag, "_year"}, bus.year,     2022);
    check({tag, "_leap"}, bus.leap,     0);
    check({tag, "_roll"}, bus.day_roll, 0);
  endtask

  // Monitor: every rising edge with a queued expectation is compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk18);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ss",       bus.ss,       e.ss);
        check("mm",       bus.mm,       e.mm);
        check("hh",       bus.hh,       e.hh);
        check("day",      bus.day,      e.day);
        check("mon",      bus.mon,      e.mon);
        check("year",     bus.year,     e.year);
        check("leap",     bus.leap,     32'(e.leap));
        check("day_roll", bus.day_roll, 32'(e.roll));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, f;
    rst = 1'b1;
    bus.tick = 0; bus.set_en = 0; bus.set_field = 3'd7; bus.set_inc = 0;
    model_reset();
    repeat (3) @(negedge clk18);
    check_reset_values("reset");
    rst = 1'b0;

    // 60 seconds with irregular idle gaps
    for (int i = 0; i < 60; i++) begin
      step(1, 0, 7, 0);
      if ($urandom_range(0, 3) == 0) step(0, 0, 7, 0);
    end

    // year-end rollover with day_roll pulse
    preload(2022, 12, 31, 23, 59, 59);
    step(1, 0, 7, 0);
    step(0, 0, 7, 0);
    step(0, 0, 7, 0);

    // leap and non-leap February, century wrap
    preload(2024, 2, 28, 23, 59, 59);
    step(1, 0, 7, 0);
    preload(2023, 2, 28, 23, 59, 59);
    step(1, 0, 7, 0);
    preload(2099, 12, 31, 23, 59, 59);
    step(1, 0, 7, 0);
    step(0, 0, 7, 0);

    // set-mode wrap without carry; ticks lost while frozen
    set_to(0, 59);
    step(0, 1, 0, 1);
    step(1, 1, 0, 0);
    step(1, 1, 7, 0);
    step(1, 1, 3, 0);
    set_to(2, 23);
    step(0, 1, 2, 1);
    step(0, 0, 7, 0);

    // day clamp on month and year steps, no-field selects
    preload(2024, 1, 31, 10, 20, 30);
    step(0, 1, 4, 1);
    step(0, 1, 5, 1);
    step(0, 1, 7, 1);
    step(0, 1, 6, 1);
    set_to(4, 3); set_to(3, 31);
    step(0, 1, 4, 1);
    step(0, 0, 7, 0);

    // async reset between ticks, then tick and set_inc together in run mode
    for (int i = 0; i < 5; i++) step(1, 0, 7, 0);
    step(0, 0, 7, 0);
    @(posedge clk18);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("midrun_rst");
    model_reset();
    @(negedge clk18);
    rst = 1'b0;
    step(1, 0, 0, 1);
    step(1, 0, 4, 1);
    step(0, 0, 5, 1);

    // randomised mix
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      f = $urandom_range(0, 7);
      if (r < 65)      step(1, 0, f, 1'($urandom_range(0, 1)));
      else if (r < 75) step(0, 0, f, 1'($urandom_range(0, 1)));
      else if (r < 95) step(1'($urandom_range(0, 1)), 1, f, 1'($urandom_range(0, 1)));
      else begin
        int y, mo;
        y  = $urandom_range(2000, 2099);
        mo = $urandom_range(1, 12);
        preload(y, mo, dim(mo, y), 23, 59, $urandom_range(55, 59));
      end
    end

    step(0, 0, 7, 0);
    repeat (2) @(posedge clk18);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
